// File: rtl/nmr_acq_pkg.sv
// -----------------------------------------------------------------------------
// nmr_acq_pkg
// Shared definitions for the NMR acquisition chain. This package holds:
//   - the accumulator width that the upstream running-sum stage uses
//   - the default echo index width
//   - the two-state echo window enum
//   - the FIFO entry layout {idx, sum}
// -----------------------------------------------------------------------------
package nmr_acq_pkg;

  localparam int ACC_W = 20;
  localparam int IDX_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    INTEG = 1'b1
  } echo_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] sum;
  } echo_entry_t;

endpackage : nmr_acq_pkg

// File: rtl/echo_sum_fifo.sv
// -----------------------------------------------------------------------------
// echo_sum_fifo
// Synchronous first-word-fall-through FIFO. It has DEPTH entries of W bits.
// Full and empty come from read and write pointers that carry one extra wrap
// bit, so no separate occupancy counter is needed.
//
// Handshake: a push is accepted when push_i=1 and either the FIFO is not full
// or a pop occurs in the same cycle. A pop occurs when pop_i=1 and the FIFO is
// not empty. An ignored request has no effect on the FIFO.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset; empties the FIFO
//   push_i   in   write request
//   din_i    in   [W-1:0] write data
//   pop_i    in   read request (the head advances on the next edge)
//   dout_o   out  [W-1:0] head entry. It is zero while the FIFO is empty.
//   empty_o  out  no entries
//   full_o   out  DEPTH entries
// -----------------------------------------------------------------------------
module echo_sum_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         wr_en;
  logic         rd_en;

  // Same index with a different wrap bit means the writer is one lap ahead.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rd_en = pop_i && !empty_o;
  // When the FIFO is full, a pop in the same cycle frees the slot that this
  // push writes.
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // The storage array has no reset. The output gate below keeps stale
  // contents off dout_o.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule : echo_sum_fifo

// File: rtl/echo_sum_capture.sv
// -----------------------------------------------------------------------------
// echo_sum_capture
// Per-echo integral extractor. The upstream accumulator is never cleared.
// This block takes a snapshot of that running sum when an echo window opens.
// When the window closes, it pushes {echo index, end - base} into a FWFT FIFO.
// The subtraction is modulo 2^ACC_W, so a wrap of the upstream sum inside one
// window still gives the correct integral.
//
// Optional feature: define ECHO_TIMEOUT_EN to add a window length counter.
// With it, a window that stays open for MAX_LEN cycles without echo_end is
// closed. Nothing is pushed and the index does not advance. The sticky output
// "timeout" is then set; clr_ovf clears it.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   addresult   in   [ACC_W-1:0] running sum from the accumulator
//   echo_start  in   pulse that opens (or re-bases) the echo window
//   echo_end    in   pulse that closes the window and pushes a result
//   train_clr   in   pulse that zeroes the echo index
//   rd_en       in   pop request; ignored when empty
//   dout_sum    out  [ACC_W-1:0] integral of the head entry
//   dout_idx    out  [IDX_W-1:0] echo index of the head entry
//   empty       out  FIFO empty
//   full        out  FIFO full
//   ovf         out  sticky: a result was dropped because the FIFO was full
//   clr_ovf     in   clears ovf (and timeout); a new set in the same cycle wins
//   busy        out  echo window open (state INTEG); this is the FSM state
//   timeout     out  (ECHO_TIMEOUT_EN only) sticky window timeout
// -----------------------------------------------------------------------------
module echo_sum_capture #(
  parameter int ACC_W   = nmr_acq_pkg::ACC_W,
  parameter int IDX_W   = nmr_acq_pkg::IDX_W,
  parameter int DEPTH   = 16
`ifdef ECHO_TIMEOUT_EN
  ,
  parameter int MAX_LEN = 4096
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] addresult,
  input  logic             echo_start,
  input  logic             echo_end,
  input  logic             train_clr,
  input  logic             rd_en,
  output logic [ACC_W-1:0] dout_sum,
  output logic [IDX_W-1:0] dout_idx,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  input  logic             clr_ovf,
  output logic             busy
`ifdef ECHO_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  import nmr_acq_pkg::*;

  localparam int ENT_W = IDX_W + ACC_W;

  echo_state_e      state_q, state_d;
  logic [ACC_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;

  logic             push;
  logic             drop;
  logic [ACC_W-1:0] sum;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] head_data;
  logic             fifo_empty;
  logic             fifo_full;

`ifdef ECHO_TIMEOUT_EN
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

  logic [LEN_W-1:0] len_q, len_d;
  logic             tmo_q, tmo_d;
  logic             tmo_set;
`endif

  // Unsigned subtraction absorbs any wrap of the upstream running sum.
  assign sum       = addresult - base_q;
  assign push_data = {idx_q, sum};

  // When the FIFO is full, rd_en always makes a real pop. So the only drop
  // case is full without rd_en.
  assign drop = push && fifo_full && !rd_en;

  // Window FSM. Every echo_start that is accepted starts a new window from the
  // current addresult. echo_end is only meaningful in INTEG.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    push    = 1'b0;
`ifdef ECHO_TIMEOUT_EN
    tmo_set = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (echo_start) begin
          base_d  = addresult;
          state_d = INTEG;
        end
      end
      INTEG: begin
        if (echo_end) begin
          push = 1'b1;
          // A coincident start re-opens the window at the same sample.
          if (echo_start) base_d = addresult;
          else            state_d = IDLE;
        end else if (echo_start) begin
          base_d = addresult;
        end
`ifdef ECHO_TIMEOUT_EN
        else if (len_q == LEN_LAST) begin
          state_d = IDLE;
          tmo_set = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // train_clr has priority over the increment. A coincident push still
  // carries the old index, because push_data uses idx_q.
  always_comb begin
    idx_d = idx_q;
    if (train_clr) idx_d = '0;
    else if (push) idx_d = idx_q + 1'b1;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

`ifdef ECHO_TIMEOUT_EN
  // len_q is the number of cycles already spent in the current window. Any
  // echo_start restarts the count.
  always_comb begin
    len_d = '0;
    if (state_d == INTEG && !echo_start) len_d = len_q + 1'b1;
    tmo_d = tmo_q;
    if (tmo_set)      tmo_d = 1'b1;
    else if (clr_ovf) tmo_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      len_q <= len_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  echo_sum_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (rd_en),
    .dout_o  (head_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign dout_sum = head_data[ACC_W-1:0];
  assign dout_idx = head_data[ENT_W-1:ACC_W];
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign ovf      = ovf_q;
  assign busy     = (state_q == INTEG);

endmodule : echo_sum_capture

// File: tb/tb_echo_sum_capture.sv
// -----------------------------------------------------------------------------
// tb_echo_sum_capture
// Directed and random stimulus for echo_sum_capture. A behavioural model
// tracks the echo window, the index and the FIFO occupancy. Each accepted
// result goes into exp_q. The monitor removes the head of exp_q whenever the
// DUT pops an entry, and also checks the status flags.
// Inputs change 1 time unit after the rising edge. The monitor samples on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_echo_sum_capture;

  localparam int ACC_W = 20;
  localparam int IDX_W = 8;
  localparam int DEPTH = 16;
  localparam int ENT_W = ACC_W + IDX_W;
`ifdef ECHO_TIMEOUT_EN
  localparam int MAX_LEN = 8;
`endif

  logic             clk;
  logic             rst;
  logic [ACC_W-1:0] addresult;
  logic             echo_start, echo_end, train_clr, rd_en, clr_ovf;
  logic [ACC_W-1:0] dout_sum;
  logic [IDX_W-1:0] dout_idx;
  logic             empty, full, ovf, busy;
`ifdef ECHO_TIMEOUT_EN
  logic             timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  echo_sum_capture #(
    .ACC_W (ACC_W),
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
`ifdef ECHO_TIMEOUT_EN
    ,
    .MAX_LEN (MAX_LEN)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addresult  (addresult),
    .echo_start (echo_start),
    .echo_end   (echo_end),
    .train_clr  (train_clr),
    .rd_en      (rd_en),
    .dout_sum   (dout_sum),
    .dout_idx   (dout_idx),
    .empty      (empty),
    .full       (full),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf),
    .busy       (busy)
`ifdef ECHO_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model follows the behaviour from a higher level: whether a window is
  // open, its base sample, the next echo index, and how many results the FIFO
  // holds.
  logic [ENT_W-1:0] exp_q[$];
  bit               m_open = 0;
  logic [ACC_W-1:0] m_base = '0;
  logic [IDX_W-1:0] m_idx  = '0;
  int               m_cnt  = 0;
  bit               m_ovf  = 0;
  bit               m_tmo  = 0;
  int               m_len  = 0;

  always @(posedge clk or posedge rst) begin : model
    bit pop, result, drop;
    if (rst) begin
      exp_q.delete();
      m_open = 0; m_base = '0; m_idx = '0; m_cnt = 0;
      m_ovf = 0; m_tmo = 0; m_len = 0;
    end else begin
      pop    = rd_en && (m_cnt > 0);
      result = m_open && echo_end;
      drop   = 0;
      if (result) begin
        if (m_cnt < DEPTH || pop) begin
          exp_q.push_back({m_idx, ACC_W'(addresult - m_base)});
          m_cnt++;
        end else begin
          drop = 1;
        end
      end
      if (pop) m_cnt--;
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (train_clr) m_idx = '0;
      else if (result) m_idx = m_idx + 1'b1;
      // The window: a start always begins a new window; an end closes it
      // unless a start comes in the same cycle.
      if (echo_start) begin
        m_open = 1; m_base = addresult; m_len = 0;
      end else if (result) begin
        m_open = 0;
      end else if (m_open) begin
`ifdef ECHO_TIMEOUT_EN
        m_len++;
        if (m_len == MAX_LEN) begin
          m_open = 0;
          m_tmo  = 1;
        end else if (clr_ovf) begin
          m_tmo = 0;
        end
`endif
      end
`ifdef ECHO_TIMEOUT_EN
      if (!(m_open == 0 && m_len == MAX_LEN) && clr_ovf) m_tmo = 0;
      if (!m_open) m_len = 0;
`endif
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [ENT_W-1:0] e;
    chk("empty", {31'd0, empty}, {31'd0, (m_cnt == 0)});
    chk("full",  {31'd0, full},  {31'd0, (m_cnt == DEPTH)});
    chk("ovf",   {31'd0, ovf},   {31'd0, m_ovf});
    chk("busy",  {31'd0, busy},  {31'd0, m_open});
`ifdef ECHO_TIMEOUT_EN
    chk("timeout", {31'd0, timeout}, {31'd0, m_tmo});
`endif
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        chk("pop_without_expected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("dout_sum", {12'd0, dout_sum}, {12'd0, e[ACC_W-1:0]});
        chk("dout_idx", {24'd0, dout_idx}, {24'd0, e[ENT_W-1:ACC_W]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [ACC_W-1:0] a, input logic s, input logic e,
                       input logic tc, input logic rd, input logic co);
    addresult  = a;
    echo_start = s;
    echo_end   = e;
    train_clr  = tc;
    rd_en      = rd;
    clr_ovf    = co;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(addresult, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive('0, 0, 0, 0, 0, 0);
    for (int i = 1; i < n; i++) drive('0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic echo(input logic [ACC_W-1:0] a0, input logic [ACC_W-1:0] a1);
    drive(a0, 1, 0, 0, 0, 0);
    drive(a1, 0, 1, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && !empty; i++) drive(addresult, 0, 0, 0, 1, 0);
    chk("drain_empty", {31'd0, empty}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    addresult = '0; echo_start = 0; echo_end = 0; train_clr = 0; rd_en = 0; clr_ovf = 0;
    @(posedge clk); #1;
    do_reset(2);
    // During reset the flags are already checked by the monitor. Here, check
    // the output data values right after reset.
    chk("rst_dout_sum", {12'd0, dout_sum}, 32'd0);
    chk("rst_dout_idx", {24'd0, dout_idx}, 32'd0);

    // Basic integral: 1800 - 1000.
    drive(20'd1000, 1, 0, 0, 0, 0);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("empty_before_end", {31'd0, empty}, 32'd1);
    drive(20'd1800, 0, 1, 0, 0, 0);
    chk("basic_empty_fall", {31'd0, empty}, 32'd0);
    chk("basic_sum", {12'd0, dout_sum}, 32'd800);
    chk("basic_idx", {24'd0, dout_idx}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    drive(20'd0, 0, 0, 0, 1, 0);

    // The upstream sum wraps inside the window.
    echo(20'hFFF00, 20'h00100);
    chk("wrap_sum", {12'd0, dout_sum}, 32'h200);
    chk("wrap_idx", {24'd0, dout_idx}, 32'd1);
    drive(20'd0, 0, 0, 0, 1, 0);

    // Coincident start+end: push 300, then measure the next echo from 500.
    drive(20'd200, 1, 0, 0, 0, 0);
    drive(20'd500, 1, 1, 0, 0, 0);
    chk("coinc_sum", {12'd0, dout_sum}, 32'd300);
    chk("coinc_busy", {31'd0, busy}, 32'd1);
    drive(20'd800, 0, 1, 0, 1, 0);
    chk("rebase_sum", {12'd0, dout_sum}, 32'd300);
    chk("rebase_idx", {24'd0, dout_idx}, 32'd3);
    drive(20'd0, 0, 0, 0, 1, 0);

    // echo_end while idle is ignored.
    drive(20'd5, 0, 1, 0, 0, 0);
    chk("idle_end_ignored", {31'd0, empty}, 32'd1);

    // train_clr after 3 echoes; then a coincident train_clr with a push.
    for (int i = 0; i < 3; i++) echo(20'(i * 10), 20'(i * 10 + 7));
    drive(20'd0, 0, 0, 1, 0, 0);
    echo(20'd40, 20'd45);
    drain();
    drive(20'd10, 1, 0, 0, 0, 0);
    drive(20'd30, 0, 1, 1, 0, 0);
    echo(20'd50, 20'd51);
    chk("trclr_head_idx", {24'd0, dout_idx}, 32'd1);
    drain();

    // Reset in the middle of a window discards the FIFO and the base.
    echo(20'd1, 20'd9);
    drive(20'd100, 1, 0, 0, 0, 0);
    do_reset(1);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    drive(20'd200, 0, 1, 0, 0, 0);
    chk("midrst_no_entry", {31'd0, empty}, 32'd1);

    // 17 echoes with no reads: the 17th is dropped, and the next echo gets
    // idx 17.
    for (int i = 0; i < 17; i++) echo(20'(i), 20'(i + 100));
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_head_idx", {24'd0, dout_idx}, 32'd0);
    drive(20'd0, 0, 0, 0, 1, 0);
    echo(20'd1000, 20'd1017);
    drive(20'd0, 0, 0, 0, 0, 1);
    chk("ovf_clear", {31'd0, ovf}, 32'd0);
    drain();

`ifdef ECHO_TIMEOUT_EN
    // Withhold echo_end for 10 cycles.
    drive(20'd7, 1, 0, 0, 0, 0);
    idle(10);
    chk("tmo_set", {31'd0, timeout}, 32'd1);
    chk("tmo_no_push", {31'd0, empty}, 32'd1);
    drive(20'd0, 0, 0, 0, 0, 1);
`endif

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1);
      end else begin
        drive(20'($urandom()), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 29) == 0));
      end
    end
    drain();
    chk("final_exp_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_echo_sum_capture
